// File: rtl/stream_rr_arbiter.sv
// Purpose:      round-robin share of one valid/ready packet stream among N_SRC masters,
//               grant locked per packet, with a beat watchdog that force-ends long packets.
// Latency:      1 cycle src_valid -> m_valid (arbitration cycle); datapath combinational in LOCK.
// Backpressure: m_ready passes straight to the granted source's src_ready; others see 0.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   src_valid/data/last per-source beat stream (source i data at [i*PACK_SIZE +: PACK_SIZE])
//   src_ready           per-source ready, only the granted bit can be 1
//   m_valid/data/last   downstream beat stream (m_last is src_last or watchdog end)
//   m_ready             downstream ready
//   grant               registered one-hot grant, 0 when idle
//   overrun             sticky flag, set when a packet is force-terminated
module stream_rr_arbiter #(
    parameter int N_SRC     = 4,
    parameter int PACK_SIZE = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_SRC-1:0]           src_valid,
    input  logic [N_SRC*PACK_SIZE-1:0] src_data,
    input  logic [N_SRC-1:0]           src_last,
    output logic [N_SRC-1:0]           src_ready,
    output logic                       m_valid,
    output logic [PACK_SIZE-1:0]       m_data,
    output logic                       m_last,
    input  logic                       m_ready,
    output logic [N_SRC-1:0]           grant,
    output logic                       overrun
);

    localparam int IDXW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CW   = $clog2(MAX_BEATS + 1);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t            r_state, w_state_nxt;
    logic [N_SRC-1:0]  r_grant, w_grant_nxt;
    logic [IDXW-1:0]   r_ptr, w_ptr_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic              r_overrun, w_overrun_nxt;

    logic [IDXW-1:0]   w_pick;
    logic [IDXW-1:0]   w_scan_idx;
    logic              w_found;
    logic [N_SRC-1:0]  w_pick_oh;
    logic [IDXW-1:0]   w_gidx;
    logic              w_g_valid;
    logic              w_g_last;
    logic [PACK_SIZE-1:0] w_g_data;
    logic              w_lock;
    logic              w_wdog_end;
    logic              w_hs;

    // Round-robin scan starting just after the last served source.
    always_comb begin
        w_pick     = '0;
        w_found    = 1'b0;
        w_scan_idx = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            w_scan_idx = IDXW'((int'(r_ptr) + k) % N_SRC);
            if (!w_found && src_valid[w_scan_idx]) begin
                w_found = 1'b1;
                w_pick  = w_scan_idx;
            end
        end
    end

    assign w_pick_oh = {{(N_SRC-1){1'b0}}, 1'b1} << w_pick;

    // Grant is one-hot, so OR-reducing the masked lanes yields the granted lane.
    always_comb begin
        w_gidx    = '0;
        w_g_valid = 1'b0;
        w_g_last  = 1'b0;
        w_g_data  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (r_grant[i]) begin
                w_gidx    = IDXW'(i);
                w_g_valid = src_valid[i];
                w_g_last  = src_last[i];
                w_g_data  = src_data[i*PACK_SIZE +: PACK_SIZE];
            end
        end
    end

    assign w_lock     = (r_state == LOCK);
    assign w_wdog_end = (r_cnt == CW'(MAX_BEATS - 1));

    // Outputs are forced quiet while reset is held so no beat is accepted.
    assign m_valid   = ~reset & w_lock & w_g_valid;
    assign m_data    = w_g_data;
    assign m_last    = w_g_last | w_wdog_end;
    assign src_ready = (~reset & w_lock & m_ready) ? r_grant : '0;
    assign grant     = r_grant;
    assign overrun   = r_overrun;

    assign w_hs = m_valid & m_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_overrun_nxt = r_overrun;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = LOCK;
                    w_grant_nxt = w_pick_oh;
                    w_cnt_nxt   = '0;
                end else begin
                    w_grant_nxt = '0;
                end
            end
            LOCK: begin
                if (w_hs) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                    if (m_last) begin
                        w_state_nxt = IDLE;
                        w_grant_nxt = '0;
                        w_ptr_nxt   = w_gidx;
                        w_cnt_nxt   = '0;
                        // Watchdog end: the source's remaining beats start a new packet later.
                        if (!w_g_last) begin
                            w_overrun_nxt = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_ptr     <= IDXW'(N_SRC - 1);
            r_cnt     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Purpose:      directed scenarios plus randomized traffic against a packet-queue model.
// Latency:      inputs change 1 time unit after posedge, outputs sampled 1 unit later.
// Backpressure: m_ready patterns directed or random; sources pop only on model handshakes.
module tb_stream_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 16;

    logic           clk;
    logic           reset;
    logic [N-1:0]   src_valid;
    logic [N*W-1:0] src_data;
    logic [N-1:0]   src_last;
    logic [N-1:0]   src_ready;
    logic           m_valid;
    logic [W-1:0]   m_data;
    logic           m_last;
    logic           m_ready;
    logic [N-1:0]   grant;
    logic           overrun;

    int vectors;
    int miscompares;

    stream_rr_arbiter #(.N_SRC(N), .PACK_SIZE(W), .MAX_BEATS(MB)) dut (
        .clk       (clk),
        .reset     (reset),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_last  (src_last),
        .src_ready (src_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .grant     (grant),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven, outputs sampled after #1.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Per-source beat queues for the random phase.
    logic [W-1:0] q_dat [N][$];
    logic         q_lst [N][$];

    task automatic push_pkt(input int s);
        int len;
        len = $urandom_range(1, 20);
        for (int b = 0; b < len; b++) begin
            q_dat[s].push_back(W'($urandom));
            q_lst[s].push_back(b == len - 1);
        end
    endtask

    logic [3:0] exp3 [9];
    logic [6:0] pat4;
    int         sent;
    int         hs_obs;

    // Model state for the random phase.
    bit         md_busy;
    int         md_g;
    int         md_ptr;
    int         md_beats;
    bit         md_ovr;
    bit         exp_last;
    logic [N-1:0] drv_v;

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        src_valid   = '0;
        src_data    = '0;
        src_last    = '0;
        m_ready     = 1'b0;

        // 1: reset with all sources requesting, src0 wins first after release.
        src_valid = 4'hF;
        cyc(); cyc();
        chk("rst_grant",   32'(grant), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_ready",   32'(src_ready), 0);
        chk("rst_overrun", 32'(overrun), 0);
        reset = 1'b0;
        cyc();
        chk("t1_grant", 32'(grant), 32'h1);
        src_valid = 4'b0001; src_last = 4'b0001; m_ready = 1'b1;
        #1;
        chk("t1_m_last", 32'(m_last), 1);
        cyc();
        chk("t1_idle", 32'(grant), 0);
        src_valid = '0; src_last = '0;

        // 2: src2 three-beat packet.
        src_valid = 4'b0100; src_data[2*W +: W] = 8'hA1;
        #1;
        chk("t2_idle_mv", 32'(m_valid), 0);
        cyc();
        chk("t2_grant", 32'(grant), 32'h4);
        chk("t2_d1", 32'(m_data), 32'hA1);
        chk("t2_l1", 32'(m_last), 0);
        cyc();
        src_data[2*W +: W] = 8'hA2;
        #1;
        chk("t2_d2", 32'(m_data), 32'hA2);
        chk("t2_l2", 32'(m_last), 0);
        cyc();
        src_data[2*W +: W] = 8'hA3; src_last[2] = 1'b1;
        #1;
        chk("t2_d3", 32'(m_data), 32'hA3);
        chk("t2_l3", 32'(m_last), 1);
        cyc();
        chk("t2_end", 32'(grant), 0);
        src_valid = '0; src_last = '0;

        // 3: everyone sends 1-beat packets back to back.
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        exp3 = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        src_valid = 4'hF; src_last = 4'hF; m_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            cyc();
            chk($sformatf("t3_seq%0d", k), 32'(grant), 32'(exp3[k]));
        end
        cyc();
        src_valid = '0; src_last = '0;

        // 4: src1 four beats under stalling m_ready.
        pat4 = 7'b1010101;
        src_valid = 4'b0010; src_data[1*W +: W] = 8'h10; m_ready = 1'b0;
        cyc();
        chk("t4_grant", 32'(grant), 32'h2);
        sent = 0; hs_obs = 0;
        for (int i = 0; i < 7; i++) begin
            m_ready = pat4[6-i];
            src_data[1*W +: W] = W'(8'h10 + sent);
            src_last[1] = (sent == 3);
            #1;
            chk($sformatf("t4_data%0d", i), 32'(m_data), 32'(8'h10 + sent));
            chk($sformatf("t4_rdy%0d", i), 32'(src_ready), m_ready ? 32'h2 : 32'h0);
            chk($sformatf("t4_last%0d", i), 32'(m_last), 32'(sent == 3));
            if (m_valid && m_ready) hs_obs++;
            sent += int'(m_ready);
            cyc();
        end
        chk("t4_hs_count", 32'(hs_obs), 4);
        chk("t4_end", 32'(grant), 0);
        src_valid = '0; src_last = '0;

        // 5: src3 runaway packet, watchdog ends it at beat 16.
        m_ready = 1'b1;
        src_valid = 4'b1000; src_data[3*W +: W] = 8'h30;
        cyc();
        chk("t5_grant", 32'(grant), 32'h8);
        for (sent = 0; sent < 16; sent++) begin
            src_data[3*W +: W] = W'(8'h30 + sent);
            #1;
            chk($sformatf("t5_d%0d", sent), 32'(m_data), 32'(8'h30 + sent));
            chk($sformatf("t5_l%0d", sent), 32'(m_last), 32'(sent == 15));
            cyc();
        end
        src_data[3*W +: W] = W'(8'h30 + 16);
        #1;
        chk("t5_gap_grant", 32'(grant), 0);
        chk("t5_overrun",   32'(overrun), 1);
        chk("t5_gap_mv",    32'(m_valid), 0);
        cyc();
        chk("t5_regrant", 32'(grant), 32'h8);
        for (sent = 16; sent < 20; sent++) begin
            src_data[3*W +: W] = W'(8'h30 + sent);
            src_last[3] = (sent == 19);
            #1;
            chk($sformatf("t5_d%0d", sent), 32'(m_data), 32'(8'h30 + sent));
            chk($sformatf("t5_l%0d", sent), 32'(m_last), 32'(sent == 19));
            cyc();
        end
        chk("t5_end", 32'(grant), 0);
        chk("t5_sticky", 32'(overrun), 1);
        src_valid = '0; src_last = '0;

        // 6: reset in the middle of a src0 packet (ptr moved to 1 first).
        src_valid = 4'b0010; src_last = 4'b0010;
        cyc(); cyc();
        src_valid = 4'b0001; src_last = '0; src_data[0 +: W] = 8'h01;
        cyc();
        chk("t6_grant", 32'(grant), 32'h1);
        cyc();
        src_data[0 +: W] = 8'h02; reset = 1'b1;
        #1;
        chk("t6_rst_mv",  32'(m_valid), 0);
        chk("t6_rst_rdy", 32'(src_ready), 0);
        cyc();
        chk("t6_rst_grant", 32'(grant), 0);
        chk("t6_rst_ovr",   32'(overrun), 0);
        reset = 1'b0; src_valid = 4'hF;
        cyc();
        chk("t6_regrant0", 32'(grant), 32'h1);
        src_last = 4'hF;
        cyc();
        src_valid = '0; src_last = '0;

        // Random traffic against per-source packet queues.
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        md_busy = 0; md_g = 0; md_ptr = N - 1; md_beats = 0; md_ovr = 0;
        for (int s = 0; s < N; s++) begin
            q_dat[s].delete();
            q_lst[s].delete();
        end
        for (int c = 0; c < 1500; c++) begin
            for (int s = 0; s < N; s++) begin
                if (q_dat[s].size() == 0 && $urandom_range(0, 3) == 0) push_pkt(s);
                drv_v[s] = (q_dat[s].size() != 0) && ($urandom_range(0, 3) != 0);
                src_valid[s] = drv_v[s];
                src_data[s*W +: W] = (q_dat[s].size() != 0) ? q_dat[s][0] : W'($urandom);
                src_last[s] = (q_dat[s].size() != 0) ? q_lst[s][0] : 1'($urandom);
            end
            m_ready = ($urandom_range(0, 3) != 0);
            #1;
            chk("rnd_grant", 32'(grant), md_busy ? (32'h1 << md_g) : 32'h0);
            chk("rnd_overrun", 32'(overrun), 32'(md_ovr));
            if (md_busy) begin
                chk("rnd_m_valid", 32'(m_valid), 32'(drv_v[md_g]));
                chk("rnd_ready", 32'(src_ready), m_ready ? (32'h1 << md_g) : 32'h0);
                if (drv_v[md_g]) begin
                    exp_last = q_lst[md_g][0] || (md_beats == MB - 1);
                    chk("rnd_data", 32'(m_data), 32'(q_dat[md_g][0]));
                    chk("rnd_last", 32'(m_last), 32'(exp_last));
                    if (m_ready) begin
                        if (exp_last) begin
                            if (!q_lst[md_g][0]) md_ovr = 1;
                            md_busy = 0;
                            md_ptr  = md_g;
                        end
                        void'(q_dat[md_g].pop_front());
                        void'(q_lst[md_g].pop_front());
                        md_beats++;
                    end
                end
            end else begin
                chk("rnd_idle_mv",  32'(m_valid), 0);
                chk("rnd_idle_rdy", 32'(src_ready), 0);
                for (int k = 1; k <= N; k++) begin
                    if (!md_busy && drv_v[(md_ptr + k) % N]) begin
                        md_busy  = 1;
                        md_g     = (md_ptr + k) % N;
                        md_beats = 0;
                    end
                end
            end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
